serial_word_feeder: RTL and testbench

- Parallel-in, serial-out stage directly upstream of the Moore non-overlapping sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk on ser_out, which drives the detector's din.
- A one-word holding buffer allows back-to-back words to stream with no idle bit between them.
- Marks word boundaries with word_start and word_done for downstream logging and checking.

---
 rtl/serial_word_feeder.sv | 102 ++++++++++
 tb/tb_serial_word_feeder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
// Parallel-in, serial-out word feeder with a one-word holding buffer.
// Streams words one bit per clock and flags the first and last bit of each word.
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_start,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             accept;
  logic [WIDTH-1:0] sh_next;

  assign load_ready = reset & ~hold_full_q;
  assign accept     = load_valid & load_ready;

  // Zero-filled shift toward whichever end drives ser_out.
  assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sh_d    = load_data;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != CntLast) begin
          sh_d  = sh_next;
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
          end
        end else begin
          // Last bit: chain the next word with no gap, buffered word first.
          cnt_d = '0;
          if (hold_full_q) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sh_d = load_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    ser_valid  = (state_q == StShift);
    ser_out    = ser_valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : IDLE_BIT;
    word_start = ser_valid & (cnt_q == '0);
    word_done  = ser_valid & (cnt_q == CntLast);
    busy       = ser_valid | hold_full_q;
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: MSB-first and LSB-first instances,
// expected bit streams queued on accept and compared as bits leave ser_out.
module tb_serial_word_feeder;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic b;
    logic s;
    logic d;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         lv0 = 1'b0, lv1 = 1'b0;
  logic [W-1:0] ld0 = '0, ld1 = '0;
  logic         lr0, so0, sv0, ws0, wd0, by0;
  logic         lr1, so1, sv1, ws1, wd1, by1;

  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   det_clr = 1'b0;
  int   det_cnt = 0;
  int   det_len = 0;
  logic [3:0] det_win = '0;
  ent_t q0[$];
  ent_t q1[$];
  int   words0 = 0;
  int   words1 = 0;

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (lv0),
    .load_ready (lr0),
    .load_data  (ld0),
    .ser_out    (so0),
    .ser_valid  (sv0),
    .word_start (ws0),
    .word_done  (wd0),
    .busy       (by0)
  );

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .load_valid (lv1),
    .load_ready (lr1),
    .load_data  (ld1),
    .ser_out    (so1),
    .ser_valid  (sv1),
    .word_start (ws1),
    .word_done  (wd1),
    .busy       (by1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compares one cycle of outputs against the head of a scoreboard queue.
  task automatic mon_cmp(input string tag, input logic sv, input logic so, input logic ws,
                         input logic wd, input logic by, input logic lr, input int qsize,
                         input int words, input ent_t e);
    check({tag, "_busy"}, 32'(by), 32'(qsize != 0));
    check({tag, "_ready"}, 32'(lr), 32'(reset && (words < 2)));
    if (qsize == 0) begin
      check({tag, "_idle_valid"}, 32'(sv), 32'd0);
      check({tag, "_idle_out"}, 32'(so), 32'd0);
      check({tag, "_idle_flags"}, 32'({ws, wd}), 32'd0);
    end else begin
      check({tag, "_stall"}, 32'(sv), 32'd1);
      check({tag, "_bit"}, 32'(so), 32'(e.b));
      check({tag, "_start"}, 32'(ws), 32'(e.s));
      check({tag, "_done"}, 32'(wd), 32'(e.d));
    end
  endtask

  always @(negedge clk) begin : mon0
    ent_t e;
    if (mon_en) begin
      e = '0;
      if (q0.size() != 0) e = q0[0];
      mon_cmp("msb", sv0, so0, ws0, wd0, by0, lr0, q0.size(), words0, e);
      if (q0.size() != 0) begin
        void'(q0.pop_front());
        if (e.d) words0--;
      end
      // Reference Moore detector for non-overlapping "1001" on the valid stream.
      if (det_clr) begin
        det_cnt = 0;
        det_len = 0;
        det_win = '0;
      end else if (sv0) begin
        det_win = {det_win[2:0], so0};
        det_len++;
        if (det_len >= 4 && det_win == 4'b1001) begin
          det_cnt++;
          det_len = 0;
        end
      end
      if (!reset) begin
        q0.delete();
        words0 = 0;
      end else if (lv0 && lr0) begin
        for (int i = 0; i < W; i++) q0.push_back('{b: ld0[W-1-i], s: (i == 0), d: (i == W-1)});
        words0++;
      end
    end
  end

  always @(negedge clk) begin : mon1
    ent_t e;
    if (mon_en) begin
      e = '0;
      if (q1.size() != 0) e = q1[0];
      mon_cmp("lsb", sv1, so1, ws1, wd1, by1, lr1, q1.size(), words1, e);
      if (q1.size() != 0) begin
        void'(q1.pop_front());
        if (e.d) words1--;
      end
      if (!reset) begin
        q1.delete();
        words1 = 0;
      end else if (lv1 && lr1) begin
        for (int i = 0; i < W; i++) q1.push_back('{b: ld1[i], s: (i == 0), d: (i == W-1)});
        words1++;
      end
    end
  end

  // Presents a word and returns #1 after the accepting edge.
  task automatic send(input bit which, input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    if (which) begin lv1 = 1'b1; ld1 = d; end
    else       begin lv0 = 1'b1; ld0 = d; end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (which ? lr1 : lr0) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    lv0 = 1'b0;
    lv1 = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!by0 && !by1) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(lr0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(lr0), 32'd1);
    @(posedge clk);
    #1;

    // Single word.
    send(1'b0, 8'b1001_1001);
    wait_idle();

    // Back-to-back through the holding buffer.
    send(1'b0, 8'h93);
    send(1'b0, 8'h49);
    wait_idle();

    // Late load on the last-bit cycle with hold empty.
    send(1'b0, 8'hA5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (wd0) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("late_last_seen", 32'(seen), 32'd1);
    send(1'b0, 8'h3C);
    check("late_start", 32'(ws0), 32'd1);
    wait_idle();

    // Reset during bit 4.
    send(1'b0, 8'hF0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid", 32'(sv0), 32'd0);
    check("rst_ready", 32'(lr0), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_release_ready", 32'(lr0), 32'd1);
    wait_idle();

    // LSB-first instance.
    send(1'b1, 8'h01);
    send(1'b1, 8'hB4);
    wait_idle();

    // Detector integration: 16'h9249 as two words.
    det_clr = 1'b1;
    @(posedge clk);
    #1;
    det_clr = 1'b0;
    send(1'b0, 8'h92);
    send(1'b0, 8'h49);
    wait_idle();
    check("det_matches", 32'(det_cnt), 32'd3);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
